pvr_vtx_fix_seq: RTL

Sequencer that shares one float-to-fixed converter across the per-vertex float words of the PVR front end. It accepts X, Y, Z and optionally U and V as IEEE-754 singles over a valid/ready stream. It converts each word through a single converter instance using a per-component fractional-bit setting, and presents one complete fixed-point vertex record on an output valid/ready stream. It sits between the display-list vertex parser and the triangle setup stage.

---
 rtl/pvr_vtx_fix_seq_pkg.sv | 31 +++
 rtl/pvr_vtx_fix_seq_if.sv | 31 +++
 rtl/pvr_vtx_fix_seq_ftf.sv | 30 +++
 rtl/pvr_vtx_fix_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pvr_vtx_fix_seq_pkg.sv
// Shared types and constants for the PVR vertex float-to-fixed sequencer.
package pvr_vtx_pkg;

  localparam int COMP_W   = 48;
  localparam int NUM_COMP = 5;
  localparam int FRAC_MAX = 23;

  typedef enum logic [2:0] {
    CMP_X = 3'd0,
    CMP_Y = 3'd1,
    CMP_Z = 3'd2,
    CMP_U = 3'd3,
    CMP_V = 3'd4
  } cmp_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    OUT     = 2'd3
  } state_e;

  function automatic logic [4:0] frac_clamp(input logic [7:0] f);
    return (f > 8'(FRAC_MAX)) ? 5'(FRAC_MAX) : f[4:0];
  endfunction

  function automatic cmp_e last_idx(input logic has_uv);
    return has_uv ? CMP_V : CMP_Z;
  endfunction

endpackage

// File: rtl/pvr_vtx_fix_seq_if.sv
// Vertex word input stream and fixed-point record output stream.
interface pvr_vtx_fix_seq_if #(parameter int COMP_W = 48);

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_has_uv;
  logic [7:0]        frac_xy;
  logic [7:0]        frac_z;
  logic [7:0]        frac_uv;
  logic              out_valid;
  logic              out_ready;
  logic [COMP_W-1:0] out_x;
  logic [COMP_W-1:0] out_y;
  logic [COMP_W-1:0] out_z;
  logic [COMP_W-1:0] out_u;
  logic [COMP_W-1:0] out_v;
  logic              out_has_uv;

  // master: vertex parser / record consumer side
  modport master (
    output in_valid, in_data, in_has_uv, frac_xy, frac_z, frac_uv, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_u, out_v, out_has_uv
  );

  modport slave (
    input  in_valid, in_data, in_has_uv, frac_xy, frac_z, frac_uv, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_u, out_v, out_has_uv
  );

endinterface

// File: rtl/pvr_vtx_fix_seq_ftf.sv
// Combinational IEEE-754 single to signed fixed-point converter.
// Negative values come out in one's-complement form; out-of-range shifts truncate.
module float_to_fixed #(
  parameter int OUT_W = 48
) (
  input  logic [31:0]      f_i,
  input  logic [4:0]       frac_i,
  output logic [OUT_W-1:0] fix_o
);

  logic signed [10:0] sh;
  logic        [10:0] nsh;
  logic [OUT_W-1:0]   ext;
  logic [OUT_W-1:0]   mag;

  always_comb begin
    sh  = $signed({3'b000, f_i[30:23]}) + $signed({6'b000000, frac_i}) - 11'sd150;
    nsh = 11'd0;
    ext = {{(OUT_W-24){1'b0}}, 1'b1, f_i[22:0]};
    mag = '0;
    if (sh < 0) begin
      nsh = $unsigned(-sh);
      mag = ext >> nsh;
    end else begin
      mag = ext << $unsigned(sh);
    end
    fix_o = f_i[31] ? ~mag : mag;
  end

endmodule

// File: rtl/pvr_vtx_fix_seq.sv
// Collects 3 or 5 float words per vertex, converts them through one shared
// float_to_fixed, and emits a fixed-point vertex record. Macro: PVR_VTX_FTF_PIPE_EN.
//
// state   | meaning
// IDLE    | waiting for the first word of a vertex (X)
// COLLECT | accepting Y, Z[, U, V]
// DRAIN   | all words taken, waiting for the last slot write
// OUT     | record valid, waiting for out_ready
module pvr_vtx_fix_seq #(
  parameter int COMP_W = 48
) (
  input  logic             clock,
  input  logic             reset_n,
  pvr_vtx_fix_seq_if.slave vif,
  output logic             busy
);

  import pvr_vtx_pkg::*;

  state_e            state_q;
  cmp_e              idx_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              has_uv_q;
  logic [4:0]        frac_xy_q;
  logic [4:0]        frac_z_q;
  logic [4:0]        frac_uv_q;

  logic              in_vld_q;
  cmp_e              in_tag_q;
  logic [31:0]       in_data_q;

  logic [COMP_W-1:0] x_q, y_q, z_q, u_q, v_q;

  logic              accept;
  logic              first_acc;
  logic              last_acc;
  logic [4:0]        frac_sel;
  logic              in_zero;
  logic [COMP_W-1:0] conv_res;
  logic              wr_en;
  cmp_e              wr_tag;
  logic [COMP_W-1:0] wr_val;
  logic              wr_last;

  assign accept    = vif.in_valid & in_ready_q;
  assign first_acc = accept && (state_q == IDLE);
  assign last_acc  = accept && (state_q == COLLECT) && (idx_q == last_idx(has_uv_q));

  always_comb begin
    frac_sel = frac_uv_q;
    case (in_tag_q)
      CMP_X, CMP_Y: frac_sel = frac_xy_q;
      CMP_Z:        frac_sel = frac_z_q;
      default:      frac_sel = frac_uv_q;
    endcase
  end

  // Zero and denormal inputs both map to exactly 0, regardless of sign.
  assign in_zero = (in_data_q[30:23] == 8'd0);

  float_to_fixed #(.OUT_W(COMP_W)) u_ftf (
    .f_i    (in_data_q),
    .frac_i (frac_sel),
    .fix_o  (conv_res)
  );

`ifdef PVR_VTX_FTF_PIPE_EN
  logic              pp_vld_q;
  logic              pp_zero_q;
  cmp_e              pp_tag_q;
  logic [COMP_W-1:0] pp_res_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pp_vld_q  <= 1'b0;
      pp_zero_q <= 1'b0;
      pp_tag_q  <= CMP_X;
      pp_res_q  <= '0;
    end else begin
      pp_vld_q <= in_vld_q;
      if (in_vld_q) begin
        pp_zero_q <= in_zero;
        pp_tag_q  <= in_tag_q;
        pp_res_q  <= conv_res;
      end
    end
  end

  assign wr_en  = pp_vld_q;
  assign wr_tag = pp_tag_q;
  assign wr_val = pp_zero_q ? '0 : pp_res_q;
`else
  assign wr_en  = in_vld_q;
  assign wr_tag = in_tag_q;
  assign wr_val = in_zero ? '0 : conv_res;
`endif

  assign wr_last = wr_en && (wr_tag == last_idx(has_uv_q));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= CMP_X;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      has_uv_q    <= 1'b0;
      frac_xy_q   <= 5'd0;
      frac_z_q    <= 5'd0;
      frac_uv_q   <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            has_uv_q  <= vif.in_has_uv;
            frac_xy_q <= frac_clamp(vif.frac_xy);
            frac_z_q  <= frac_clamp(vif.frac_z);
            frac_uv_q <= frac_clamp(vif.frac_uv);
            idx_q     <= CMP_Y;
            busy_q    <= 1'b1;
            state_q   <= COLLECT;
          end
        end
        COLLECT: begin
          if (last_acc) begin
            idx_q      <= CMP_X;
            in_ready_q <= 1'b0;
            state_q    <= DRAIN;
          end else if (accept) begin
            idx_q <= cmp_e'(idx_q + 3'd1);
          end
        end
        DRAIN: begin
          if (wr_last) begin
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (vif.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Slots are cleared when a new vertex starts so U/V read 0 for XYZ-only vertices.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_vld_q  <= 1'b0;
      in_tag_q  <= CMP_X;
      in_data_q <= 32'd0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      u_q       <= '0;
      v_q       <= '0;
    end else begin
      in_vld_q <= accept;
      if (accept) begin
        in_tag_q  <= idx_q;
        in_data_q <= vif.in_data;
      end
      if (wr_en) begin
        case (wr_tag)
          CMP_X:   x_q <= wr_val;
          CMP_Y:   y_q <= wr_val;
          CMP_Z:   z_q <= wr_val;
          CMP_U:   u_q <= wr_val;
          default: v_q <= wr_val;
        endcase
      end else if (first_acc) begin
        x_q <= '0;
        y_q <= '0;
        z_q <= '0;
        u_q <= '0;
        v_q <= '0;
      end
    end
  end

  assign vif.in_ready   = in_ready_q;
  assign vif.out_valid  = out_valid_q;
  assign vif.out_x      = x_q;
  assign vif.out_y      = y_q;
  assign vif.out_z      = z_q;
  assign vif.out_u      = u_q;
  assign vif.out_v      = v_q;
  assign vif.out_has_uv = has_uv_q;
  assign busy           = busy_q;

endmodule
